// File: rtl/oldland_exception_ctrl_pkg.sv
// Shared definitions for the Oldland exception sequencer:
// cause codes, vector offsets and FSM encodings.
package oldland_exception_ctrl_pkg;

  typedef enum logic [2:0] {
    EXC_CAUSE_NONE    = 3'd0,
    EXC_CAUSE_ILLEGAL = 3'd1,
    EXC_CAUSE_IRQ     = 3'd3,
    EXC_CAUSE_IFETCH  = 3'd4,
    EXC_CAUSE_DABORT  = 3'd5
  } exc_cause_t;

  localparam logic [5:0] EXC_VEC_ILLEGAL = 6'h04;
  localparam logic [5:0] EXC_VEC_IRQ     = 6'h0C;
  localparam logic [5:0] EXC_VEC_IFETCH  = 6'h10;
  localparam logic [5:0] EXC_VEC_DABORT  = 6'h14;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_ENTER = 2'd2
  } exc_state_t;

  function automatic logic [5:0] exc_vec_offset(
    input exc_cause_t c
  );
    case (c)
      EXC_CAUSE_ILLEGAL: return EXC_VEC_ILLEGAL;
      EXC_CAUSE_IRQ:     return EXC_VEC_IRQ;
      EXC_CAUSE_IFETCH:  return EXC_VEC_IFETCH;
      EXC_CAUSE_DABORT:  return EXC_VEC_DABORT;
      default:           return 6'h00;
    endcase
  endfunction

  // Cause codes are not ordered by urgency, so rank them explicitly.
  function automatic logic [2:0] exc_rank(
    input exc_cause_t c
  );
    case (c)
      EXC_CAUSE_DABORT:  return 3'd4;
      EXC_CAUSE_IFETCH:  return 3'd3;
      EXC_CAUSE_ILLEGAL: return 3'd2;
      EXC_CAUSE_IRQ:     return 3'd1;
      default:           return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/oldland_exception_ctrl.sv
// Exception/IRQ entry sequencer: accept, stall+flush,
// drain in-flight memory ops, then strobe entry and redirect fetch.
module oldland_exception_ctrl
  import oldland_exception_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [25:0] vector_base,
  input  logic        irqs_enabled,
  input  logic        irq_req,
  input  logic        illegal_instr,
  input  logic        ifetch_abort,
  input  logic        data_abort_req,
  input  logic        mem_busy,
  input  logic [31:0] next_pc,
  output logic        pipeline_stall,
  output logic        pipeline_flush,
  output logic        exception_start,
  output logic        exception_disable_irqs,
  output logic        irq_start,
  output logic        data_abort,
  output logic [31:0] irq_fault_address,
  output logic        exc_branch,
  output logic [31:0] exc_target,
  output logic [2:0]  exc_cause
);

  localparam logic [3:0] CNT_INIT = 4'(DRAIN_CYCLES - 1);

  function automatic exc_cause_t pick_cause(
    input logic dab,
    input logic ifa,
    input logic ill,
    input logic irq
  );
    if (dab)      return EXC_CAUSE_DABORT;
    else if (ifa) return EXC_CAUSE_IFETCH;
    else if (ill) return EXC_CAUSE_ILLEGAL;
    else if (irq) return EXC_CAUSE_IRQ;
    else          return EXC_CAUSE_NONE;
  endfunction

  exc_state_t  state_q;
  exc_cause_t  cause_q;
  logic [3:0]  cnt_q;
  logic        stall_q;
  logic        flush_q;
  logic        start_q;
  logic        irq_start_q;
  logic        dabort_q;
  logic [31:0] fault_q;
  logic [31:0] target_q;

  exc_cause_t acc_cause_d;
  exc_cause_t urg_cause_d;
  exc_cause_t drn_cause_d;
  logic       drain_done_d;

  always_comb begin
    acc_cause_d = pick_cause(data_abort_req, ifetch_abort,
                             illegal_instr,
                             irq_req && irqs_enabled);
    urg_cause_d = pick_cause(data_abort_req, ifetch_abort,
                             1'b0, 1'b0);
    drn_cause_d = cause_q;
    if (exc_rank(urg_cause_d) > exc_rank(cause_q))
      drn_cause_d = urg_cause_d;
    drain_done_d = (cnt_q == 4'd0) && !mem_busy;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cause_q     <= EXC_CAUSE_NONE;
      cnt_q       <= 4'd0;
      stall_q     <= 1'b0;
      flush_q     <= 1'b0;
      start_q     <= 1'b0;
      irq_start_q <= 1'b0;
      dabort_q    <= 1'b0;
      fault_q     <= 32'd0;
      target_q    <= 32'd0;
    end else begin
      flush_q     <= 1'b0;
      start_q     <= 1'b0;
      irq_start_q <= 1'b0;
      dabort_q    <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (acc_cause_d != EXC_CAUSE_NONE) begin
            state_q <= ST_DRAIN;
            stall_q <= 1'b1;
            flush_q <= 1'b1;
            cause_q <= acc_cause_d;
            cnt_q   <= CNT_INIT;
            if (acc_cause_d == EXC_CAUSE_IRQ)
              fault_q <= next_pc;
          end
        end
        ST_DRAIN: begin
          cause_q <= drn_cause_d;
          if (cnt_q != 4'd0)
            cnt_q <= cnt_q - 4'd1;
          if (drain_done_d) begin
            state_q     <= ST_ENTER;
            start_q     <= 1'b1;
            irq_start_q <= drn_cause_d == EXC_CAUSE_IRQ;
            dabort_q    <= drn_cause_d == EXC_CAUSE_DABORT;
            target_q    <= {vector_base,
                            exc_vec_offset(drn_cause_d)};
          end
        end
        ST_ENTER: begin
          state_q <= ST_IDLE;
          stall_q <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          stall_q <= 1'b0;
        end
      endcase
    end
  end

  assign pipeline_stall         = stall_q;
  assign pipeline_flush         = flush_q;
  assign exception_start        = start_q;
  assign exception_disable_irqs = start_q;
  assign exc_branch             = start_q;
  assign irq_start              = irq_start_q;
  assign data_abort             = dabort_q;
  assign irq_fault_address      = fault_q;
  assign exc_target             = target_q;
  assign exc_cause              = cause_q;

endmodule

// File: tb/tb_oldland_exception_ctrl.sv
// Bench for oldland_exception_ctrl: directed scenarios plus
// randomized traffic against a transaction-level model.
module tb_oldland_exception_ctrl;

  localparam int DC = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [25:0] vector_base = '0;
  logic        irqs_enabled = 1'b0;
  logic        irq_req = 1'b0;
  logic        illegal_instr = 1'b0;
  logic        ifetch_abort = 1'b0;
  logic        data_abort_req = 1'b0;
  logic        mem_busy = 1'b0;
  logic [31:0] next_pc = '0;
  logic        pipeline_stall;
  logic        pipeline_flush;
  logic        exception_start;
  logic        exception_disable_irqs;
  logic        irq_start;
  logic        data_abort;
  logic [31:0] irq_fault_address;
  logic        exc_branch;
  logic [31:0] exc_target;
  logic [2:0]  exc_cause;

  always #5 clk = ~clk;

  oldland_exception_ctrl #(.DRAIN_CYCLES(DC)) dut (
    .clk(clk),
    .rst(rst),
    .vector_base(vector_base),
    .irqs_enabled(irqs_enabled),
    .irq_req(irq_req),
    .illegal_instr(illegal_instr),
    .ifetch_abort(ifetch_abort),
    .data_abort_req(data_abort_req),
    .mem_busy(mem_busy),
    .next_pc(next_pc),
    .pipeline_stall(pipeline_stall),
    .pipeline_flush(pipeline_flush),
    .exception_start(exception_start),
    .exception_disable_irqs(exception_disable_irqs),
    .irq_start(irq_start),
    .data_abort(data_abort),
    .irq_fault_address(irq_fault_address),
    .exc_branch(exc_branch),
    .exc_target(exc_target),
    .exc_cause(exc_cause)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: one pending exception, a countdown of
  // cycles still owed to the drain, and urgency by list order.
  int          urgency[4] = '{5, 4, 1, 3};
  bit          m_act, m_ent;
  int          m_left, m_cause;
  logic [31:0] m_fault, m_target;
  bit          e_stall, e_flush, e_start, e_irq, e_dab;

  function automatic int rank(input int c);
    for (int i = 0; i < 4; i++)
      if (urgency[i] == c) return 4 - i;
    return 0;
  endfunction

  function automatic logic [31:0] vec_off(input int c);
    case (c)
      1: return 32'h04;
      3: return 32'h0C;
      4: return 32'h10;
      5: return 32'h14;
      default: return 32'h00;
    endcase
  endfunction

  task automatic m_reset();
    m_act = 0; m_ent = 0; m_left = 0; m_cause = 0;
    m_fault = 0; m_target = 0;
    e_stall = 0; e_flush = 0; e_start = 0;
    e_irq = 0; e_dab = 0;
  endtask

  task automatic m_step();
    int c;
    e_flush = 0; e_start = 0; e_irq = 0; e_dab = 0;
    if (m_ent) begin
      m_ent = 0; m_act = 0; e_stall = 0;
    end else if (!m_act) begin
      c = 0;
      for (int i = 3; i >= 0; i--) begin
        if ((urgency[i] == 5 && data_abort_req) ||
            (urgency[i] == 4 && ifetch_abort) ||
            (urgency[i] == 1 && illegal_instr) ||
            (urgency[i] == 3 && irq_req && irqs_enabled))
          c = urgency[i];
      end
      if (c != 0) begin
        m_act = 1; e_stall = 1; e_flush = 1;
        m_cause = c; m_left = DC;
        if (c == 3) m_fault = next_pc;
      end
    end else begin
      c = data_abort_req ? 5 : (ifetch_abort ? 4 : 0);
      if (rank(c) > rank(m_cause)) m_cause = c;
      if (m_left > 0) m_left--;
      if (m_left == 0 && !mem_busy) begin
        m_ent = 1; e_start = 1;
        e_irq = (m_cause == 3);
        e_dab = (m_cause == 5);
        m_target = {vector_base, 6'b0} | vec_off(m_cause);
      end
    end
  endtask

  task automatic compare();
    check("stall", pipeline_stall, e_stall);
    check("flush", pipeline_flush, e_flush);
    check("start", exception_start, e_start);
    check("disirq", exception_disable_irqs, e_start);
    check("branch", exc_branch, e_start);
    check("irq_start", irq_start, e_irq);
    check("data_abort", data_abort, e_dab);
    check("cause", exc_cause, m_cause);
    check("fault_addr", irq_fault_address, m_fault);
    if (e_start) check("target", exc_target, m_target);
  endtask

  task automatic cycle();
    if (rst) m_reset();
    else m_step();
    @(posedge clk);
    #1;
    compare();
    illegal_instr = 0;
    ifetch_abort = 0;
    data_abort_req = 0;
  endtask

  task automatic run_to_start(input int budget,
                              output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!exception_start && n < budget);
    check("start_seen", exception_start, 1);
  endtask

  int n;

  initial begin
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    compare();
    rst = 0;
    cycle();

    // 1: illegal instruction, minimum latency
    vector_base = 26'h1;
    illegal_instr = 1;
    cycle();
    check("t1_stall", pipeline_stall, 1);
    check("t1_flush", pipeline_flush, 1);
    run_to_start(50, n);
    check("t1_latency", n, DC);
    check("t1_target", exc_target, 32'h44);
    check("t1_cause", exc_cause, 1);
    check("t1_irq", irq_start, 0);
    repeat (2) cycle();

    // 2: masked irq, then enabled
    irq_req = 1;
    repeat (20) cycle();
    check("t2_nostall", pipeline_stall, 0);
    next_pc = 32'h1000;
    irqs_enabled = 1;
    run_to_start(50, n);
    irqs_enabled = 0;
    check("t2_irq", irq_start, 1);
    check("t2_target", exc_target, 32'h4C);
    check("t2_fault", irq_fault_address, 32'h1000);
    irq_req = 0;
    repeat (3) cycle();

    // 3: dabort overrides an accepted irq
    irqs_enabled = 1;
    irq_req = 1;
    next_pc = 32'h2000;
    cycle();
    irq_req = 0;
    cycle();
    data_abort_req = 1;
    run_to_start(50, n);
    irqs_enabled = 0;
    check("t3_dab", data_abort, 1);
    check("t3_irq", irq_start, 0);
    check("t3_off", {26'b0, exc_target[5:0]}, 32'h14);
    check("t3_fault", irq_fault_address, 32'h2000);
    repeat (3) cycle();

    // 4: mem_busy stretches the drain
    illegal_instr = 1;
    mem_busy = 1;
    cycle();
    repeat (9) cycle();
    check("t4_wait", exception_start, 0);
    mem_busy = 0;
    cycle();
    check("t4_enter", exception_start, 1);
    cycle();
    check("t4_width", exception_start, 0);
    repeat (2) cycle();

    // 5: asynchronous reset mid-drain
    illegal_instr = 1;
    cycle();
    cycle();
    #3;
    rst = 1;
    #1;
    m_reset();
    compare();
    check("t5_stall", pipeline_stall, 0);
    #2;
    rst = 0;
    repeat (6) cycle();

    // 6: simultaneous sources
    irqs_enabled = 1;
    irq_req = 1;
    illegal_instr = 1;
    ifetch_abort = 1;
    cycle();
    irq_req = 0;
    run_to_start(50, n);
    irqs_enabled = 0;
    check("t6_cause", exc_cause, 4);
    check("t6_off", {26'b0, exc_target[5:0]}, 32'h10);
    repeat (4) cycle();
    check("t6_idle", pipeline_stall, 0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 31) == 0)
        vector_base = 26'($urandom);
      next_pc = $urandom;
      irqs_enabled = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) irq_req = ~irq_req;
      mem_busy = ($urandom_range(0, 9) < 3);
      illegal_instr = ($urandom_range(0, 9) == 0);
      ifetch_abort = ($urandom_range(0, 14) == 0);
      data_abort_req = ($urandom_range(0, 19) == 0);
      cycle();
      if ($urandom_range(0, 299) == 0) begin
        #2;
        rst = 1;
        #1;
        m_reset();
        compare();
        cycle();
        rst = 0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
